// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_pkg
// Description : Shared encodings for the RV32I-subset controllers: opcode and
//               funct field constants, ALU / ImmSrc / ResultSrc / operand-mux
//               encodings, main-FSM state codes and the branch-condition
//               helper. The single-cycle and pipelined controllers use the
//               same encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_controller_pkg;

    // Opcodes (IR[6:0])
    localparam logic [6:0] c_OP_LW   = 7'b0000011;
    localparam logic [6:0] c_OP_SW   = 7'b0100011;
    localparam logic [6:0] c_OP_R    = 7'b0110011;
    localparam logic [6:0] c_OP_I    = 7'b0010011;
    localparam logic [6:0] c_OP_BR   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL  = 7'b1101111;
    localparam logic [6:0] c_OP_JALR = 7'b1100111;
    localparam logic [6:0] c_OP_LUI  = 7'b0110111;

    // ALU funct3 values
    localparam logic [2:0] c_F3_ADD  = 3'b000;
    localparam logic [2:0] c_F3_SLL  = 3'b001;
    localparam logic [2:0] c_F3_SLT  = 3'b010;
    localparam logic [2:0] c_F3_SLTU = 3'b011;
    localparam logic [2:0] c_F3_XOR  = 3'b100;
    localparam logic [2:0] c_F3_SR   = 3'b101;
    localparam logic [2:0] c_F3_OR   = 3'b110;
    localparam logic [2:0] c_F3_AND  = 3'b111;

    // Branch / jalr funct3 values
    localparam logic [2:0] c_F3_BEQ  = 3'b000;
    localparam logic [2:0] c_F3_BNE  = 3'b001;
    localparam logic [2:0] c_F3_BLT  = 3'b100;
    localparam logic [2:0] c_F3_BGE  = 3'b101;
    localparam logic [2:0] c_F3_JALR = 3'b000;

    // funct7 values
    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    // ALUControl
    localparam logic [2:0] c_ALU_ADD  = 3'b000;
    localparam logic [2:0] c_ALU_SUB  = 3'b001;
    localparam logic [2:0] c_ALU_AND  = 3'b010;
    localparam logic [2:0] c_ALU_OR   = 3'b011;
    localparam logic [2:0] c_ALU_XOR  = 3'b100;
    localparam logic [2:0] c_ALU_SLT  = 3'b101;
    localparam logic [2:0] c_ALU_SLTU = 3'b110;

    // ALUOp: how the ALU decoder picks the operation
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    // ImmSrc
    localparam logic [2:0] c_IMM_I = 3'b000;
    localparam logic [2:0] c_IMM_S = 3'b001;
    localparam logic [2:0] c_IMM_B = 3'b010;
    localparam logic [2:0] c_IMM_J = 3'b011;
    localparam logic [2:0] c_IMM_U = 3'b100;

    // ResultSrc
    localparam logic [1:0] c_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] c_RES_MEMDATA   = 2'b01;
    localparam logic [1:0] c_RES_ALURESULT = 2'b10;
    localparam logic [1:0] c_RES_IMMEXT    = 2'b11;

    // ALUSrcA / ALUSrcB
    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_REGA  = 2'b10;
    localparam logic [1:0] c_SRCB_REGB  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM   = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b10;

    // Main-FSM state codes
    typedef logic [3:0] state_t;
    localparam state_t c_S_IDLE     = 4'd0;
    localparam state_t c_S_FETCH    = 4'd1;
    localparam state_t c_S_DECODE   = 4'd2;
    localparam state_t c_S_MEMADR   = 4'd3;
    localparam state_t c_S_MEMREAD  = 4'd4;
    localparam state_t c_S_MEM_WB   = 4'd5;
    localparam state_t c_S_MEMWRITE = 4'd6;
    localparam state_t c_S_EXEC_R   = 4'd7;
    localparam state_t c_S_EXEC_I   = 4'd8;
    localparam state_t c_S_ALU_WB   = 4'd9;
    localparam state_t c_S_BRANCH   = 4'd10;
    localparam state_t c_S_JALR_ADR = 4'd11;
    localparam state_t c_S_JUMP     = 4'd12;
    localparam state_t c_S_LUI_WB   = 4'd13;
    localparam state_t c_S_ILLEGAL  = 4'd14;
    localparam state_t c_S_HALT     = 4'd15;

    // Branch condition from the SUB flags. Signed overflow is deliberately
    // ignored, so blt/bge use the raw sign bit. Unknown funct3: not taken.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       neg);
        logic taken;
        case (funct3)
            c_F3_BEQ: taken = zero;
            c_F3_BNE: taken = ~zero;
            c_F3_BLT: taken = neg;
            c_F3_BGE: taken = ~neg;
            default:  taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mc_alu_decoder
// Description : Combinational ALU decoder for the multicycle controller.
//               ALUOp 00 -> ADD, 01 -> SUB, 10 -> decode from funct3/funct7.
//               The unsupported flag marks R/I-type encodings that this core
//               does not implement (shifts, unknown funct7); it depends only
//               on the instruction fields so DECODE can use it directly.
// Ports       : op[6:0], funct3[2:0], funct7[6:0], ALUOp[1:0] (in)
//               ALUControl[2:0], unsupported (out)
// Revision    : 1.0 - initial release
// ============================================================================
module mc_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl,
    output logic       unsupported
);

    logic w_is_r;
    logic w_is_alu;
    logic w_bad_f7;
    logic w_bad_f3;

    assign w_is_r   = (op == c_OP_R);
    assign w_is_alu = w_is_r || (op == c_OP_I);
    assign w_bad_f7 = w_is_r && (funct7 != c_F7_BASE) && (funct7 != c_F7_ALT);
    assign w_bad_f3 = (funct3 == c_F3_SLL) || (funct3 == c_F3_SR);

    assign unsupported = w_is_alu && (w_bad_f3 || w_bad_f7);

    always_comb begin
        ALUControl = c_ALU_ADD;
        case (ALUOp)
            c_ALUOP_SUB: ALUControl = c_ALU_SUB;
            c_ALUOP_FUNCT: begin
                case (funct3)
                    // I-type funct7 bits are immediate bits, so only R-type
                    // can select SUB.
                    c_F3_ADD:  ALUControl = (w_is_r && funct7 == c_F7_ALT) ? c_ALU_SUB : c_ALU_ADD;
                    c_F3_AND:  ALUControl = c_ALU_AND;
                    c_F3_OR:   ALUControl = c_ALU_OR;
                    c_F3_XOR:  ALUControl = c_ALU_XOR;
                    c_F3_SLT:  ALUControl = c_ALU_SLT;
                    c_F3_SLTU: ALUControl = c_ALU_SLTU;
                    default:   ALUControl = c_ALU_ADD;
                endcase
            end
            default: ALUControl = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main FSM for the multicycle RV32I-subset core. Sequences the
//               shared ALU and unified memory per instruction, waiting on
//               MemReady for every fetch and data access.
// Parameters  : ILLEGAL_HALT - 1: unsupported encoding parks in HALT until
//               reset; 0: unsupported encoding returns to FETCH.
// Ports       : clk, rst (async, active-low), op, funct3, funct7, Zero, Neg,
//               MemReady (in); MemReq, AdrSrc, MemWrite, IRWrite, PCWrite,
//               RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc,
//               IllegalInstr, InstrRetired (out)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    input  logic       Neg,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic       IllegalInstr,
    output logic       InstrRetired
);

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_aluop;
    logic       w_unsupported;

    mc_alu_decoder u_alu_decoder (
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .ALUOp       (w_aluop),
        .ALUControl  (ALUControl),
        .unsupported (w_unsupported)
    );

    // State register. Reset is asynchronous so outputs (all Moore on
    // r_state) drop in the same cycle rst goes low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:     w_next_state = c_S_FETCH;
            c_S_FETCH:    w_next_state = MemReady ? c_S_DECODE : c_S_FETCH;
            c_S_DECODE: begin
                case (op)
                    c_OP_LW,
                    c_OP_SW:   w_next_state = c_S_MEMADR;
                    c_OP_R:    w_next_state = w_unsupported ? c_S_ILLEGAL : c_S_EXEC_R;
                    c_OP_I:    w_next_state = w_unsupported ? c_S_ILLEGAL : c_S_EXEC_I;
                    c_OP_BR:   w_next_state = c_S_BRANCH;
                    c_OP_JAL:  w_next_state = c_S_JUMP;
                    c_OP_JALR: w_next_state = (funct3 == c_F3_JALR) ? c_S_JALR_ADR : c_S_ILLEGAL;
                    c_OP_LUI:  w_next_state = c_S_LUI_WB;
                    default:   w_next_state = c_S_ILLEGAL;
                endcase
            end
            c_S_MEMADR:   w_next_state = (op == c_OP_LW) ? c_S_MEMREAD : c_S_MEMWRITE;
            c_S_MEMREAD:  w_next_state = MemReady ? c_S_MEM_WB : c_S_MEMREAD;
            c_S_MEM_WB:   w_next_state = c_S_FETCH;
            c_S_MEMWRITE: w_next_state = MemReady ? c_S_FETCH : c_S_MEMWRITE;
            c_S_EXEC_R,
            c_S_EXEC_I:   w_next_state = c_S_ALU_WB;
            c_S_ALU_WB:   w_next_state = c_S_FETCH;
            c_S_BRANCH:   w_next_state = c_S_FETCH;
            c_S_JALR_ADR: w_next_state = c_S_JUMP;
            c_S_JUMP:     w_next_state = c_S_ALU_WB;
            c_S_LUI_WB:   w_next_state = c_S_FETCH;
            c_S_ILLEGAL:  w_next_state = ILLEGAL_HALT ? c_S_HALT : c_S_FETCH;
            c_S_HALT:     w_next_state = c_S_HALT;
            default:      w_next_state = c_S_IDLE;
        endcase
    end

    // Output logic. Every output defaults to its IDLE/HALT value of 0.
    always_comb begin
        MemReq       = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = c_RES_ALUOUT;
        ALUSrcA      = c_SRCA_PC;
        ALUSrcB      = c_SRCB_REGB;
        ImmSrc       = c_IMM_I;
        IllegalInstr = 1'b0;
        InstrRetired = 1'b0;
        w_aluop      = c_ALUOP_ADD;
        case (r_state)
            c_S_FETCH: begin
                // PC+4 goes straight from the ALU into PC while IR loads.
                MemReq    = 1'b1;
                ALUSrcB   = c_SRCB_FOUR;
                ResultSrc = c_RES_ALURESULT;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            c_S_DECODE: begin
                // Speculatively compute the jump/branch target into ALUOut.
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_IMM;
                ImmSrc  = (op == c_OP_JAL) ? c_IMM_J : c_IMM_B;
            end
            c_S_MEMADR: begin
                ALUSrcA = c_SRCA_REGA;
                ALUSrcB = c_SRCB_IMM;
                ImmSrc  = (op == c_OP_SW) ? c_IMM_S : c_IMM_I;
            end
            c_S_MEMREAD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            c_S_MEM_WB: begin
                ResultSrc    = c_RES_MEMDATA;
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
            end
            c_S_MEMWRITE: begin
                MemReq       = 1'b1;
                AdrSrc       = 1'b1;
                MemWrite     = 1'b1;
                InstrRetired = MemReady;
            end
            c_S_EXEC_R: begin
                ALUSrcA = c_SRCA_REGA;
                w_aluop = c_ALUOP_FUNCT;
            end
            c_S_EXEC_I: begin
                ALUSrcA = c_SRCA_REGA;
                ALUSrcB = c_SRCB_IMM;
                w_aluop = c_ALUOP_FUNCT;
            end
            c_S_ALU_WB: begin
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
            end
            c_S_BRANCH: begin
                // ALUOut still holds the target computed in DECODE.
                ALUSrcA      = c_SRCA_REGA;
                w_aluop      = c_ALUOP_SUB;
                PCWrite      = branch_taken(funct3, Zero, Neg);
                InstrRetired = 1'b1;
            end
            c_S_JALR_ADR: begin
                ALUSrcA = c_SRCA_REGA;
                ALUSrcB = c_SRCB_IMM;
            end
            c_S_JUMP: begin
                // PC <- target in ALUOut while the ALU forms OldPC+4 for rd.
                PCWrite = 1'b1;
                ALUSrcA = c_SRCA_OLDPC;
                ALUSrcB = c_SRCB_FOUR;
            end
            c_S_LUI_WB: begin
                ImmSrc       = c_IMM_U;
                ResultSrc    = c_RES_IMMEXT;
                RegWrite     = 1'b1;
                InstrRetired = 1'b1;
            end
            c_S_ILLEGAL: IllegalInstr = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed bench for multicycle_controller. Two instances share
//               the stimulus: dut_a (ILLEGAL_HALT=0) and dut_h (ILLEGAL_HALT=1).
//               All outputs are packed into one vector per instance and
//               compared each cycle against hand-written expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero, Neg, MemReady;

    logic       a_mreq, a_adr, a_mw, a_irw, a_pcw, a_rw, a_ill, a_ret;
    logic [1:0] a_rs, a_sa, a_sb;
    logic [2:0] a_alu, a_imm;
    logic       h_mreq, h_adr, h_mw, h_irw, h_pcw, h_rw, h_ill, h_ret;
    logic [1:0] h_rs, h_sa, h_sb;
    logic [2:0] h_alu, h_imm;

    logic [19:0] outs_a, outs_h;
    assign outs_a = {a_mreq, a_adr, a_mw, a_irw, a_pcw, a_rw, a_rs, a_sa, a_sb, a_alu, a_imm, a_ill, a_ret};
    assign outs_h = {h_mreq, h_adr, h_mw, h_irw, h_pcw, h_rw, h_rs, h_sa, h_sb, h_alu, h_imm, h_ill, h_ret};

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .Neg(Neg), .MemReady(MemReady),
        .MemReq(a_mreq), .AdrSrc(a_adr), .MemWrite(a_mw), .IRWrite(a_irw),
        .PCWrite(a_pcw), .RegWrite(a_rw), .ResultSrc(a_rs), .ALUSrcA(a_sa),
        .ALUSrcB(a_sb), .ALUControl(a_alu), .ImmSrc(a_imm),
        .IllegalInstr(a_ill), .InstrRetired(a_ret)
    );

    multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_h (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .Neg(Neg), .MemReady(MemReady),
        .MemReq(h_mreq), .AdrSrc(h_adr), .MemWrite(h_mw), .IRWrite(h_irw),
        .PCWrite(h_pcw), .RegWrite(h_rw), .ResultSrc(h_rs), .ALUSrcA(h_sa),
        .ALUSrcB(h_sb), .ALUControl(h_alu), .ImmSrc(h_imm),
        .IllegalInstr(h_ill), .InstrRetired(h_ret)
    );

    // Packs expected output fields in the same order as outs_a/outs_h.
    function automatic logic [19:0] ov(input logic mreq, input logic adr, input logic mw,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [2:0] alu,
                                       input logic [2:0] imm, input logic ill, input logic ret);
        return {mreq, adr, mw, irw, pcw, rw, rs, sa, sb, alu, imm, ill, ret};
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    // Let combinational outputs settle, then check both instances.
    task automatic chk2(input string tag, input logic [19:0] ea, input logic [19:0] eh);
        #1;
        chk({tag, "/a"}, outs_a, ea);
        chk({tag, "/h"}, outs_h, eh);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] v_f1, v_f0, v_decb, v_decj, v_exr, v_wb, v_ill;
        logic [19:0] v_adr_i, v_adr_s, v_mr, v_jmp;
        v_f1    = ov(1,0,0,1,1,0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0,0);
        v_f0    = ov(1,0,0,0,0,0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0,0);
        v_decb  = ov(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010, 0,0);
        v_decj  = ov(0,0,0,0,0,0, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011, 0,0);
        v_exr   = ov(0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 3'b000, 3'b000, 0,0);
        v_wb    = ov(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,1);
        v_ill   = ov(0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1,0);
        v_adr_i = ov(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000, 0,0);
        v_adr_s = ov(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001, 0,0);
        v_mr    = ov(1,1,0,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0,0);
        v_jmp   = ov(0,0,0,0,1,0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0,0);

        rst = 1'b0; op = '0; funct3 = '0; funct7 = '0;
        Zero = 1'b0; Neg = 1'b0; MemReady = 1'b0;
        #1;
        chk2("reset", '0, '0);

        // add x3,x1,x2: IDLE, FETCH, DECODE, EXEC_R, ALU_WB
        #6;
        rst = 1'b1; MemReady = 1'b1; op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000;
        chk2("add_idle", '0, '0);
        step(); chk2("add_fetch", v_f1, v_f1);
        step(); chk2("add_decode", v_decb, v_decb);
        step(); chk2("add_exec", v_exr, v_exr);
        step(); chk2("add_wb", v_wb, v_wb);

        // sub: funct7=0100000 selects SUB
        step(); funct7 = 7'b0100000; chk2("sub_fetch", v_f1, v_f1);
        step(); chk2("sub_decode", v_decb, v_decb);
        step(); chk2("sub_exec", ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,0),
                                 ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,0));
        step(); chk2("sub_wb", v_wb, v_wb);

        // lw with 3 fetch waits and 2 read waits: 10 cycles total
        step(); op = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0000000; MemReady = 1'b0;
        chk2("lw_fwait1", v_f0, v_f0);
        step(); chk2("lw_fwait2", v_f0, v_f0);
        step(); chk2("lw_fwait3", v_f0, v_f0);
        step(); MemReady = 1'b1; chk2("lw_fetch", v_f1, v_f1);
        step(); MemReady = 1'b0; chk2("lw_decode", v_decb, v_decb);
        step(); chk2("lw_memadr", v_adr_i, v_adr_i);
        step(); chk2("lw_rwait1", v_mr, v_mr);
        step(); chk2("lw_rwait2", v_mr, v_mr);
        step(); MemReady = 1'b1; chk2("lw_read", v_mr, v_mr);
        step(); chk2("lw_wb", ov(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,3'b000,0,1),
                              ov(0,0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,3'b000,0,1));

        // beq Zero=1 taken; bne Zero=1 not taken
        step(); op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1; chk2("beq_fetch", v_f1, v_f1);
        step(); chk2("beq_decode", v_decb, v_decb);
        step(); chk2("beq_branch", ov(0,0,0,0,1,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,1),
                                   ov(0,0,0,0,1,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,1));
        step(); funct3 = 3'b001; chk2("bne_fetch", v_f1, v_f1);
        step(); chk2("bne_decode", v_decb, v_decb);
        step(); chk2("bne_branch", ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,1),
                                   ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,1));
        // bge Neg=0 taken; blt Neg=0 not taken
        step(); funct3 = 3'b101; Zero = 1'b0; Neg = 1'b0; chk2("bge_fetch", v_f1, v_f1);
        step(); chk2("bge_decode", v_decb, v_decb);
        step(); chk2("bge_branch", ov(0,0,0,0,1,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,1),
                                   ov(0,0,0,0,1,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,1));
        step(); funct3 = 3'b100; chk2("blt_fetch", v_f1, v_f1);
        step(); chk2("blt_decode", v_decb, v_decb);
        step(); chk2("blt_branch", ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,1),
                                   ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0,1));

        // addi with imm bits looking like funct7=0100000 must stay ADD
        step(); op = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0100000; chk2("addi_fetch", v_f1, v_f1);
        step(); chk2("addi_decode", v_decb, v_decb);
        step(); chk2("addi_exec", v_adr_i, v_adr_i);
        step(); chk2("addi_wb", v_wb, v_wb);

        // sltu
        step(); op = 7'b0110011; funct3 = 3'b011; funct7 = 7'b0000000; chk2("sltu_fetch", v_f1, v_f1);
        step(); chk2("sltu_decode", v_decb, v_decb);
        step(); chk2("sltu_exec", ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b110,3'b000,0,0),
                                  ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,3'b110,3'b000,0,0));
        step(); chk2("sltu_wb", v_wb, v_wb);

        // jalr x1,0(x1): FETCH, DECODE, JALR_ADR, JUMP, ALU_WB
        step(); op = 7'b1100111; funct3 = 3'b000; chk2("jalr_fetch", v_f1, v_f1);
        step(); chk2("jalr_decode", v_decb, v_decb);
        step(); chk2("jalr_adr", v_adr_i, v_adr_i);
        step(); chk2("jalr_jump", v_jmp, v_jmp);
        step(); chk2("jalr_wb", v_wb, v_wb);

        // jal: DECODE uses J immediate
        step(); op = 7'b1101111; chk2("jal_fetch", v_f1, v_f1);
        step(); chk2("jal_decode", v_decj, v_decj);
        step(); chk2("jal_jump", v_jmp, v_jmp);
        step(); chk2("jal_wb", v_wb, v_wb);

        // lui
        step(); op = 7'b0110111; chk2("lui_fetch", v_f1, v_f1);
        step(); chk2("lui_decode", v_decb, v_decb);
        step(); chk2("lui_wb", ov(0,0,0,0,0,1,2'b11,2'b00,2'b00,3'b000,3'b100,0,1),
                               ov(0,0,0,0,0,1,2'b11,2'b00,2'b00,3'b000,3'b100,0,1));

        // sw with MemReady=1 retires in MEMWRITE
        step(); op = 7'b0100011; funct3 = 3'b010; chk2("sw_fetch", v_f1, v_f1);
        step(); chk2("sw_decode", v_decb, v_decb);
        step(); chk2("sw_memadr", v_adr_s, v_adr_s);
        step(); chk2("sw_write", ov(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,1),
                                 ov(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,1));

        // fence opcode: dut_a pulses and returns to FETCH, dut_h parks in HALT
        step(); op = 7'b0001111; funct3 = 3'b000; chk2("fence_fetch", v_f1, v_f1);
        step(); chk2("fence_decode", v_decb, v_decb);
        step(); chk2("fence_illegal", v_ill, v_ill);
        // sll (funct3=001) is unsupported R-type
        step(); op = 7'b0110011; funct3 = 3'b001; chk2("sll_fetch", v_f1, '0);
        step(); chk2("sll_decode", v_decb, '0);
        step(); chk2("sll_illegal", v_ill, '0);
        step(); chk2("after_sll", v_f1, '0);

        // asynchronous reset, then release
        rst = 1'b0;
        chk2("rst_async", '0, '0);
        rst = 1'b1;
        chk2("rst_idle", '0, '0);
        step(); op = 7'b0100011; funct3 = 3'b010; chk2("rst_fetch", v_f1, v_f1);

        // reset in the middle of a stalled MEMWRITE
        step(); chk2("sw2_decode", v_decb, v_decb);
        step(); chk2("sw2_memadr", v_adr_s, v_adr_s);
        step(); MemReady = 1'b0;
        chk2("sw2_wait", ov(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0),
                         ov(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0,0));
        #1; rst = 1'b0;
        chk2("sw2_rst_drop", '0, '0);
        rst = 1'b1; MemReady = 1'b1;
        chk2("sw2_idle", '0, '0);
        step(); chk2("sw2_refetch", v_f1, v_f1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
